// File: rtl/adc_sar_sequencer.sv
// SAR conversion controller: synchronizes the start request, holds the sampling
// switch, runs a one-bit-per-cycle binary search on the DAC and reports the code.
module adc_sar_sequencer #(
  parameter int RESOLUTION    = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  comp_i,
  output logic                  sample_o,
  output logic [RESOLUTION-1:0] dac_code_o,
  output logic                  busy_o,
  output logic [RESOLUTION-1:0] result_o,
  output logic                  result_valid_o,
  output logic                  overrun_o
);

  localparam int IDX_W = $clog2(RESOLUTION);
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_m1;
  logic [RESOLUTION-1:0]  code_q, code_d;
  logic [RESOLUTION-1:0]  result_q, result_d;
  logic                   ovr_q, ovr_d;
  logic                   start_edge;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], start_i};
  assign hist_d     = sync_q[SYNC_STAGES-1];
  assign start_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign idx_m1     = idx_q - IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
    result_d = result_q;
    // Any edge seen outside IDLE (including the DONE->IDLE cycle) is an overrun.
    ovr_d    = ovr_q | (start_edge && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        code_d = '0;
        if (start_edge) begin
          state_d = SAMPLE;
          cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d                = CONVERT;
          code_d                 = '0;
          code_d[RESOLUTION-1]   = 1'b1;
          idx_d                  = IDX_W'(RESOLUTION - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CONVERT: begin
        if (!comp_i) code_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          code_d[idx_m1] = 1'b1;
          idx_d          = idx_m1;
        end else begin
          result_d = code_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= IDX_W'(RESOLUTION - 1);
      code_q   <= '0;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_o       = (state_q == SAMPLE);
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign dac_code_o     = code_q;
  assign result_o       = result_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Scoreboard bench for adc_sar_sequencer: ideal comparator against a random vin,
// expected codes/trial sequences/timing queued at stimulus, checked by a monitor.
module tb_adc_sar_sequencer;

  localparam int RES = 8;
  localparam int SC  = 2;
  localparam int SS  = 2;
  localparam int LAT = SS + SC + RES;  // E0 to valid strobe

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           comp_i;
  logic           sample_o;
  logic [RES-1:0] dac_code_o;
  logic           busy_o;
  logic [RES-1:0] result_o;
  logic           result_valid_o;
  logic           overrun_o;
  logic [RES-1:0] vin;

  typedef struct {
    logic [RES-1:0] code;
    int             vcyc;
  } exp_t;

  exp_t           rq[$];
  logic [RES-1:0] dq[$];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             samp_cnt = 0;
  int             samp_first = 0;

  adc_sar_sequencer #(.RESOLUTION(RES), .SAMPLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .comp_i(comp_i),
    .sample_o(sample_o), .dac_code_o(dac_code_o), .busy_o(busy_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign comp_i = (vin >= dac_code_o);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an ideal SAR with exact comparator returns vin; trials are a binary search.
  task automatic expect_conv(input logic [RES-1:0] v);
    exp_t e;
    int   acc;
    int   trial;
    e.code = v;
    e.vcyc = cyc + 1 + LAT;
    rq.push_back(e);
    acc = 0;
    for (int b = RES - 1; b >= 0; b--) begin
      trial = acc + (1 << b);
      dq.push_back(RES'(trial));
      if (int'(v) >= trial) acc = trial;
    end
  endtask

  task automatic conv(input logic [RES-1:0] v, input int len);
    @(negedge clk);
    vin = v;
    expect_conv(v);
    start_i = 1'b1;
    repeat (len) @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("drain", rq.size(), 0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_sample"}, int'(sample_o), 0);
    chk({tag, "_dac"}, int'(dac_code_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_result"}, int'(result_o), 0);
    chk({tag, "_valid"}, int'(result_valid_o), 0);
    chk({tag, "_overrun"}, int'(overrun_o), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_o) begin
        if (samp_cnt == 0) samp_first = cyc;
        samp_cnt++;
      end
      if (busy_o && !sample_o && !result_valid_o) begin
        if (dq.size() == 0) chk("dac_unexpected", int'(dac_code_o), -1);
        else chk("dac_trial", int'(dac_code_o), int'(dq.pop_front()));
      end
      if (result_valid_o) begin
        if (rq.size() == 0) begin
          chk("valid_unexpected", int'(result_o), -1);
        end else begin
          exp_t e;
          e = rq.pop_front();
          chk("result", int'(result_o), int'(e.code));
          chk("valid_cycle", cyc, e.vcyc);
          chk("sample_len", samp_cnt, SC);
          chk("sample_start", samp_first, e.vcyc - RES - SC);
        end
        samp_cnt = 0;
      end
    end
  end

  initial begin
    logic [RES-1:0] v2;
    rst = 1'b1; start_i = 1'b0; vin = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    conv(8'hA5, 4);
    chk("ovr_basic", int'(overrun_o), 0);
    conv(8'h00, 4);
    conv(8'hFF, 4);

    conv(RES'($urandom_range(0, 255)), 40);
    chk("ovr_held", int'(overrun_o), 0);

    for (int i = 0; i < 6; i++) conv(RES'($urandom_range(0, 255)), $urandom_range(3, 6));
    chk("ovr_random", int'(overrun_o), 0);

    // Back-to-back: second start sampled at E12 so its edge lands in IDLE.
    @(negedge clk);
    vin = RES'($urandom_range(0, 255));
    expect_conv(vin);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    v2 = RES'($urandom_range(0, 255));
    expect_conv(v2);
    start_i = 1'b1;
    @(negedge clk);
    vin = v2;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_drain", rq.size(), 0);
    chk("ovr_b2b", int'(overrun_o), 0);

    // Second start during CONVERT: ignored, overrun sticky.
    @(negedge clk);
    vin = RES'($urandom_range(0, 255));
    expect_conv(vin);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("ovr_drain", rq.size(), 0);
    chk("ovr_set", int'(overrun_o), 1);
    conv(RES'($urandom_range(0, 255)), 4);
    chk("ovr_sticky", int'(overrun_o), 1);

    // Reset sampled at the end of the 3rd CONVERT cycle.
    @(negedge clk);
    vin = RES'($urandom_range(0, 255));
    expect_conv(vin);
    start_i = 1'b1;
    repeat (4) @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rq.delete();
    dq.delete();
    samp_cnt = 0;
    @(negedge clk);
    chk_idle_zero("abort");
    rst = 1'b0;
    conv(8'h3C, 4);
    chk("ovr_after_rst", int'(overrun_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_sar_sequencer.md
Name: adc_sar_sequencer

Overview:
- Synchronous SAR conversion controller directly downstream of the ADC edge-detect delay stage.
- Consumes the start pulse from the edge detector, synchronizes it and detects its rising edge.
- Drives the sampling switch and a binary-search trial code to the capacitive DAC, and resolves each bit from the comparator.
- Presents the final code with a one-cycle valid strobe.

Parameters:
- RESOLUTION, 8, number of result bits (≥2).
- SAMPLE_CYCLES, 2, cycles sample_o is held high per conversion (≥1).
- SYNC_STAGES, 2, flops in the start_i synchronizer (≥2).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  conversion request from the edge-detect stage; asynchronous to clk; must stay high ≥ SYNC_STAGES+1 clk periods.
- comp_i  input  1  comparator decision for the current dac_code_o; 1 = vin ≥ DAC, keep the trial bit.
- sample_o  output  1  sampling switch enable.
- dac_code_o  output  RESOLUTION  trial code to the DAC.
- busy_o  output  1  conversion in progress.
- result_o  output  RESOLUTION  last completed conversion; holds until the next completion.
- result_valid_o  output  1  one-cycle strobe when result_o updates.
- overrun_o  output  1  sticky flag: a start edge was detected while busy.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE; all outputs 0; synchronizer and edge-history flops 0; bit index=RESOLUTION-1. Reset mid-conversion aborts immediately; result_o is cleared, not retained.
- Start detection: start_i passes through SYNC_STAGES flops. start_edge = sync_out & ~sync_out_d (sync_out_d is a one-flop history). A level held high yields exactly one edge.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: dac_code_o=0, sample_o=0, busy_o=0. On start_edge, go to SAMPLE and load the sample counter with SAMPLE_CYCLES-1.
- SAMPLE: sample_o=1, busy_o=1, dac_code_o=0. Counter decrements each cycle. At count 0, go to CONVERT, set dac_code_o = 1<<(RESOLUTION-1) and bit index = RESOLUTION-1.
- CONVERT: busy_o=1, sample_o=0. RESOLUTION cycles, one bit per cycle. At each edge, comp_i is sampled against the current dac_code_o:
  - comp_i=0: clear bit[index].
  - index>0: set bit[index-1], decrement index.
  - index==0: copy the final code to result_o, go to DONE.
- DONE: result_valid_o=1 and busy_o=1 for exactly one cycle. dac_code_o holds the final code. Then go to IDLE, where dac_code_o returns to 0.
- Latency: let E0 be the first clk edge that samples start_i=1.
  - SAMPLE entered at E0+SYNC_STAGES.
  - CONVERT entered at E0+SYNC_STAGES+SAMPLE_CYCLES.
  - DONE entered at E0+SYNC_STAGES+SAMPLE_CYCLES+RESOLUTION.
  - Defaults: SAMPLE at E2, CONVERT at E4, result_valid_o high during E12..E13, IDLE at E13.
- Start edge in SAMPLE/CONVERT/DONE: ignored for conversion purposes; overrun_o set to 1 at the next edge; cleared only by rst.
- start_edge in the same cycle DONE→IDLE: ignored and counts as an overrun. A new conversion needs an edge detected while in IDLE.
- comp_i is ignored outside CONVERT.
- No arithmetic beyond bit set/clear. The index counter is ceil(log2(RESOLUTION)) bits wide and never wraps below 0.

Test Plan:
- Defaults; comparator model comp_i = (0xA5 ≥ dac_code_o); start_i pulse 4 cycles long.
  - dac_code_o sequence over 8 CONVERT cycles is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - result_o=0xA5; result_valid_o high exactly one cycle at E12; sample_o high E2..E4; overrun_o=0.
- Boundaries: vin=0x00 → result_o=0x00; vin=0xFF → result_o=0xFF. Both meet the same E12 valid timing.
- start_i held high for 40 cycles → exactly one conversion and one valid strobe; overrun_o stays 0.
- start_i rises again (after low ≥3 cycles) during CONVERT → no second conversion; overrun_o=1 and stays 1 until rst.
- rst asserted in the 3rd CONVERT cycle → next cycle: all outputs 0, FSM in IDLE. A following start produces a correct full conversion (vin=0x3C → 0x3C).
- Back-to-back starts, second edge detected in IDLE one cycle after DONE → second conversion runs with correct timing; overrun_o=0.
